// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped cache controller.
package cache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    localparam int unsigned MISS_CNT_W = 16;

    function automatic int unsigned calc_wpl(input int unsigned offset_w, input int unsigned word_w);
        return (32'd1 << offset_w) / (word_w / 8);
    endfunction

    function automatic int unsigned calc_tag_w(input int unsigned addr_w, input int unsigned offset_w,
                                               input int unsigned index_w);
        return addr_w - offset_w - index_w;
    endfunction

    function automatic int unsigned calc_bsel_w(input int unsigned word_w);
        return $clog2(word_w / 8);
    endfunction

    function automatic int unsigned calc_wsel_w(input int unsigned offset_w, input int unsigned word_w);
        return offset_w - $clog2(word_w / 8);
    endfunction

endpackage

// File: rtl/cache_ctrl_dm_if.sv
// CPU-side request bus and memory-side port of the cache, grouped as one interface.
interface cache_ctrl_dm_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned WORD_W = 16
) ();
    import cache_pkg::*;

    logic                  req_valid;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [WORD_W-1:0]     req_wdata;
    logic [WORD_W-1:0]     rdata;
    logic                  stall;
    logic                  mem_req;
    logic [ADDR_W-1:0]     mem_raddr;
    logic                  mem_rvalid;
    logic [WORD_W-1:0]     mem_rdata;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_waddr;
    logic [WORD_W-1:0]     mem_wdata;
    logic [MISS_CNT_W-1:0] miss_count;

    // Environment side: CPU requester plus main memory.
    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rvalid, mem_rdata,
        input  rdata, stall, mem_req, mem_raddr, mem_we, mem_waddr, mem_wdata, miss_count
    );

    // Cache controller side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rvalid, mem_rdata,
        output rdata, stall, mem_req, mem_raddr, mem_we, mem_waddr, mem_wdata, miss_count
    );
endinterface

// File: rtl/cache_data_array.sv
// Line data storage: one synchronous write port, one combinational read port.
module cache_data_array #(
    parameter int unsigned LINE_W = 7,
    parameter int unsigned WSEL_W = 3,
    parameter int unsigned WORD_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [LINE_W-1:0] wline,
    input  logic [WSEL_W-1:0] wword,
    input  logic [WORD_W-1:0] wdata,
    input  logic [LINE_W-1:0] rline,
    input  logic [WSEL_W-1:0] rword,
    output logic [WORD_W-1:0] rdata
);
    localparam int unsigned DEPTH = 32'd1 << (LINE_W + WSEL_W);

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[{wline, wword}] <= wdata;
    end

    assign rdata = mem_q[{rline, rword}];
endmodule

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped, write-through, no-allocate cache controller with a pipelined
// line-fill FSM and a saturating read-miss counter.
module cache_ctrl_dm
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned WORD_W   = 16,
    parameter int unsigned OFFSET_W = 4,
    parameter int unsigned INDEX_W  = 7
) (
    input logic            clk,
    input logic            rst,
    cache_ctrl_dm_if.slave bus
);
    localparam int unsigned WPL    = calc_wpl(OFFSET_W, WORD_W);
    localparam int unsigned TAG_W  = calc_tag_w(ADDR_W, OFFSET_W, INDEX_W);
    localparam int unsigned BSEL_W = calc_bsel_w(WORD_W);
    localparam int unsigned WSEL_W = calc_wsel_w(OFFSET_W, WORD_W);
    localparam int unsigned CNT_W  = $clog2(WPL) + 1;
    localparam int unsigned LINES  = 32'd1 << INDEX_W;
    localparam logic [CNT_W-1:0] WPL_CNT  = CNT_W'(WPL);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WPL - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]      resp_cnt_q, resp_cnt_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [INDEX_W-1:0]    fill_idx_q, fill_idx_d;
    logic [TAG_W-1:0]      fill_tag_q, fill_tag_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [TAG_W-1:0]      tag_q [LINES];
    logic [TAG_W-1:0]      tag_d [LINES];
    logic [MISS_CNT_W-1:0] miss_count_q, miss_count_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_waddr_q, mem_waddr_d;
    logic [WORD_W-1:0]     mem_wdata_q, mem_wdata_d;

    logic [TAG_W-1:0]   tag_c;
    logic [INDEX_W-1:0] idx_c;
    logic [WSEL_W-1:0]  wsel_c;
    logic               hit_c;
    logic               arr_we_c;
    logic [INDEX_W-1:0] arr_line_c;
    logic [WSEL_W-1:0]  arr_word_c;
    logic [WORD_W-1:0]  arr_wdata_c;
    logic [WORD_W-1:0]  arr_rdata_c;

    assign tag_c  = bus.req_addr[ADDR_W-1 -: TAG_W];
    assign idx_c  = bus.req_addr[OFFSET_W +: INDEX_W];
    assign wsel_c = bus.req_addr[OFFSET_W-1 : BSEL_W];
    assign hit_c  = valid_q[idx_c] & (tag_q[idx_c] == tag_c);

    cache_data_array #(
        .LINE_W (INDEX_W),
        .WSEL_W (WSEL_W),
        .WORD_W (WORD_W)
    ) u_data (
        .clk   (clk),
        .we    (arr_we_c),
        .wline (arr_line_c),
        .wword (arr_word_c),
        .wdata (arr_wdata_c),
        .rline (idx_c),
        .rword (wsel_c),
        .rdata (arr_rdata_c)
    );

    // Next-state: store/miss handling in IDLE, concurrent issue and receive in FILL.
    always_comb begin
        state_d      = state_q;
        issue_cnt_d  = issue_cnt_q;
        resp_cnt_d   = resp_cnt_q;
        base_d       = base_q;
        fill_idx_d   = fill_idx_q;
        fill_tag_d   = fill_tag_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        miss_count_d = miss_count_q;
        mem_we_d     = 1'b0;
        mem_waddr_d  = mem_waddr_q;
        mem_wdata_d  = mem_wdata_q;
        arr_we_c     = 1'b0;
        arr_line_c   = idx_c;
        arr_word_c   = wsel_c;
        arr_wdata_c  = bus.req_wdata;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && bus.req_we) begin
                    mem_we_d    = 1'b1;
                    mem_waddr_d = bus.req_addr;
                    mem_wdata_d = bus.req_wdata;
                    arr_we_c    = hit_c;
                end else if (bus.req_valid && !hit_c) begin
                    state_d         = FILL;
                    base_d          = {bus.req_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    fill_idx_d      = idx_c;
                    fill_tag_d      = tag_c;
                    issue_cnt_d     = '0;
                    resp_cnt_d      = '0;
                    valid_d[idx_c]  = 1'b0;
                    if (!(&miss_count_q)) miss_count_d = miss_count_q + MISS_CNT_W'(1);
                end
            end
            FILL: begin
                if (issue_cnt_q < WPL_CNT) issue_cnt_d = issue_cnt_q + CNT_W'(1);
                if (bus.mem_rvalid && (resp_cnt_q < WPL_CNT)) begin
                    arr_we_c    = 1'b1;
                    arr_line_c  = fill_idx_q;
                    arr_word_c  = resp_cnt_q[WSEL_W-1:0];
                    arr_wdata_c = bus.mem_rdata;
                    resp_cnt_d  = resp_cnt_q + CNT_W'(1);
                    if (resp_cnt_q == LAST_CNT) begin
                        valid_d[fill_idx_q] = 1'b1;
                        tag_d[fill_idx_q]   = fill_tag_q;
                        state_d             = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            issue_cnt_q  <= '0;
            resp_cnt_q   <= '0;
            base_q       <= '0;
            fill_idx_q   <= '0;
            fill_tag_q   <= '0;
            valid_q      <= '0;
            tag_q        <= '{default: '0};
            miss_count_q <= '0;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            issue_cnt_q  <= issue_cnt_d;
            resp_cnt_q   <= resp_cnt_d;
            base_q       <= base_d;
            fill_idx_q   <= fill_idx_d;
            fill_tag_q   <= fill_tag_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            miss_count_q <= miss_count_d;
            mem_we_q     <= mem_we_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Stall and read-data/issue outputs are combinational from the flops and request.
    assign bus.stall      = (state_q == FILL) |
                            ((state_q == IDLE) & bus.req_valid & ~bus.req_we & ~hit_c);
    assign bus.rdata      = ((state_q == IDLE) & hit_c) ? arr_rdata_c : '0;
    assign bus.mem_req    = (state_q == FILL) & (issue_cnt_q < WPL_CNT);
    assign bus.mem_raddr  = base_q + (ADDR_W'(issue_cnt_q) << BSEL_W);
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_waddr  = mem_waddr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.miss_count = miss_count_q;
endmodule

// File: tb/tb_cache_ctrl_dm.sv
// Directed bench for cache_ctrl_dm with a latency-3 pipelined memory model.
module tb_cache_ctrl_dm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    cache_ctrl_dm_if #(.ADDR_W(16), .WORD_W(16)) bus ();

    cache_ctrl_dm #(
        .ADDR_W(16), .WORD_W(16), .OFFSET_W(4), .INDEX_W(7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory model: background pattern plus any written-through words.
    logic [15:0] wmem [logic [15:0]];
    logic        pipe_v [3];
    logic [15:0] pipe_d [3];
    logic [15:0] req_log [$];

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] d;
        d = a - 16'h1230;
        return 16'hA000 + (d >> 1);
    endfunction

    initial begin
        for (int i = 0; i < 3; i++) begin
            pipe_v[i] = 1'b0;
            pipe_d[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (bus.mem_we) wmem[bus.mem_waddr] = bus.mem_wdata;
        if (bus.mem_req) req_log.push_back(bus.mem_raddr);
        pipe_v[2] <= pipe_v[1];
        pipe_d[2] <= pipe_d[1];
        pipe_v[1] <= pipe_v[0];
        pipe_d[1] <= pipe_d[0];
        pipe_v[0] <= bus.mem_req;
        pipe_d[0] <= wmem.exists(bus.mem_raddr) ? wmem[bus.mem_raddr] : mem_word(bus.mem_raddr);
    end

    assign bus.mem_rvalid = pipe_v[2];
    assign bus.mem_rdata  = pipe_d[2];

    task automatic do_read(input logic [15:0] a, output int stalls, output logic [15:0] data);
        stalls = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = a;
        #1;
        while (bus.stall !== 1'b0 && stalls < 50) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        data = bus.rdata;
        if (stalls >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL read_timeout addr=%h stalls=%0d", a, stalls);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic do_store(input string name, input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = a;
        bus.req_wdata = d;
        #1;
        n_tests++;
        if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL %s_stall got=%b exp=0", name, bus.stall); end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        #1;
        n_tests++;
        if (bus.mem_we !== 1'b1 || bus.mem_waddr !== a || bus.mem_wdata !== d) begin
            n_fail++;
            $display("FAIL %s_pulse got we=%b addr=%h data=%h exp we=1 addr=%h data=%h",
                     name, bus.mem_we, bus.mem_waddr, bus.mem_wdata, a, d);
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL %s_pulse_end got=%b exp=0", name, bus.mem_we); end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.stall !== 1'b0 || bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 ||
            bus.mem_waddr !== 16'h0 || bus.mem_wdata !== 16'h0 || bus.miss_count !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state got stall=%b req=%b we=%b waddr=%h wdata=%h miss=%0d exp all zero",
                     bus.stall, bus.mem_req, bus.mem_we, bus.mem_waddr, bus.mem_wdata, bus.miss_count);
        end
    endtask

    task automatic test_read_miss();
        int s;
        logic [15:0] d;
        req_log.delete();
        do_read(16'h1234, s, d);
        n_tests++;
        if (s != 12) begin n_fail++; $display("FAIL miss_stall_cycles got=%0d exp=12", s); end
        n_tests++;
        if (d !== 16'hA002) begin n_fail++; $display("FAIL miss_rdata got=%h exp=a002", d); end
        n_tests++;
        if (req_log.size() != 8) begin
            n_fail++;
            $display("FAIL miss_req_count got=%0d exp=8", req_log.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                n_tests++;
                if (req_log[k] !== 16'h1230 + 16'(2 * k)) begin
                    n_fail++;
                    $display("FAIL miss_raddr%0d got=%h exp=%h", k, req_log[k], 16'h1230 + 16'(2 * k));
                end
            end
        end
        n_tests++;
        if (bus.miss_count !== 16'd1) begin n_fail++; $display("FAIL miss_count1 got=%0d exp=1", bus.miss_count); end
    endtask

    task automatic test_read_hit();
        int s;
        logic [15:0] d;
        req_log.delete();
        do_read(16'h123E, s, d);
        n_tests++;
        if (s != 0 || d !== 16'hA007) begin
            n_fail++;
            $display("FAIL hit_read got stalls=%0d data=%h exp stalls=0 data=a007", s, d);
        end
        n_tests++;
        if (req_log.size() != 0 || bus.miss_count !== 16'd1) begin
            n_fail++;
            $display("FAIL hit_no_mem got reqs=%0d miss=%0d exp reqs=0 miss=1", req_log.size(), bus.miss_count);
        end
    endtask

    task automatic test_store_hit();
        int s;
        logic [15:0] d;
        do_store("store_hit", 16'h1236, 16'hBEEF);
        do_read(16'h1236, s, d);
        n_tests++;
        if (s != 0 || d !== 16'hBEEF || bus.miss_count !== 16'd1) begin
            n_fail++;
            $display("FAIL store_hit_read got stalls=%0d data=%h miss=%0d exp 0 beef 1", s, d, bus.miss_count);
        end
    endtask

    task automatic test_conflict();
        int s;
        logic [15:0] d;
        do_read(16'h9230, s, d);
        n_tests++;
        if (s != 12 || d !== 16'hE000) begin
            n_fail++;
            $display("FAIL conflict_fill got stalls=%0d data=%h exp 12 e000", s, d);
        end
        do_read(16'h1230, s, d);
        n_tests++;
        if (s != 12 || d !== 16'hA000) begin
            n_fail++;
            $display("FAIL conflict_refill got stalls=%0d data=%h exp 12 a000", s, d);
        end
        n_tests++;
        if (bus.miss_count !== 16'd3) begin n_fail++; $display("FAIL miss_count3 got=%0d exp=3", bus.miss_count); end
        do_read(16'h1236, s, d);
        n_tests++;
        if (s != 0 || d !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL write_through_refill got stalls=%0d data=%h exp 0 beef", s, d);
        end
    endtask

    task automatic test_store_miss();
        int s;
        logic [15:0] d;
        do_store("store_miss", 16'h4000, 16'h1111);
        n_tests++;
        if (bus.miss_count !== 16'd3) begin n_fail++; $display("FAIL store_miss_count got=%0d exp=3", bus.miss_count); end
        do_read(16'h4000, s, d);
        n_tests++;
        if (s != 12 || d !== 16'h1111 || bus.miss_count !== 16'd4) begin
            n_fail++;
            $display("FAIL no_allocate got stalls=%0d data=%h miss=%0d exp 12 1111 4", s, d, bus.miss_count);
        end
    endtask

    task automatic test_reset_during_fill();
        int s;
        int resp;
        int cyc;
        logic [15:0] d;
        resp = 0;
        cyc  = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 16'h5678;
        while (resp < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.mem_rvalid === 1'b1) resp++;
        end
        n_tests++;
        if (resp != 3) begin n_fail++; $display("FAIL abort_resp_wait got=%0d exp=3", resp); end
        rst = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.stall !== 1'b0 || bus.mem_req !== 1'b0 || bus.miss_count !== 16'd0) begin
            n_fail++;
            $display("FAIL abort_idle got stall=%b req=%b miss=%0d exp 0 0 0", bus.stall, bus.mem_req, bus.miss_count);
        end
        req_log.delete();
        repeat (6) @(negedge clk);
        n_tests++;
        if (req_log.size() != 0) begin n_fail++; $display("FAIL abort_late got reqs=%0d exp=0", req_log.size()); end
        do_read(16'h5678, s, d);
        n_tests++;
        if (s != 12 || d !== 16'hC224 || req_log.size() != 8 || bus.miss_count !== 16'd1) begin
            n_fail++;
            $display("FAIL abort_refill got stalls=%0d data=%h reqs=%0d miss=%0d exp 12 c224 8 1",
                     s, d, req_log.size(), bus.miss_count);
        end
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_store_hit();
        test_conflict();
        test_store_miss();
        test_reset_during_fill();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/cache_ctrl_dm.md
Name: cache_ctrl_dm

Overview:
Parametrised direct-mapped cache controller, the successor to the fixed 16-bit/128-line controller. Geometry is generalised: word width, line size and line count are parameters. Adds what the fixed block lacks: a read-miss line-fill FSM over a pipelined memory port, write-through stores, a stall handshake and a saturating miss counter. It sits between the CPU memory stage (or fetch) and main memory; one instance is used for I-cache and one for D-cache.

Parameters:
ADDR_W, 16, address width in bits
WORD_W, 16, CPU and memory word width in bits; must be a multiple of 8
OFFSET_W, 4, byte-offset bits; line size is 2^OFFSET_W bytes
INDEX_W, 7, index bits; line count is 2^INDEX_W
Derived: WPL = 2^OFFSET_W/(WORD_W/8) words per line (8 at defaults); TAG_W = ADDR_W-OFFSET_W-INDEX_W (5 at defaults)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  CPU access request
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address; bits below word granularity are ignored
req_wdata  in  WORD_W  store data
rdata  out  WORD_W  load data; valid when req_valid & ~req_we & ~stall
stall  out  1  CPU must hold the request stable while this is high
mem_req  out  1  memory read request, one word per cycle
mem_raddr  out  ADDR_W  word-aligned read address
mem_rvalid  in  1  read data return, in issue order, fixed latency ≥1
mem_rdata  in  WORD_W  returned word
mem_we  out  1  write-through store pulse
mem_waddr  out  ADDR_W  store address
mem_wdata  out  WORD_W  store data
miss_count  out  16  count of read misses, saturating at 0xFFFF

Behaviour:
- Address split: tag = addr[ADDR_W-1 -: TAG_W]; index = addr[OFFSET_W +: INDEX_W]; word select = addr[OFFSET_W-1 : log2(WORD_W/8)].
- Storage: valid[2^INDEX_W], tag array, data array. Reads are combinational; writes occur on the clock edge.
- hit = valid[index] & (tag_arr[index] == tag).
- stall (combinational) = (state==FILL) | (state==IDLE & req_valid & ~req_we & ~hit).
- FSM states are IDLE and FILL.
- IDLE, read hit: rdata = selected word in the same cycle, stall=0.
- IDLE, read miss: stall=1. Latch the line base address (offset bits zeroed), index and tag. Clear issue_cnt and resp_cnt. Increment miss_count if < 0xFFFF. Go to FILL.
- FILL, issue: while issue_cnt < WPL, assert mem_req with mem_raddr = base + issue_cnt*(WORD_W/8), then issue_cnt++. One word is issued per cycle with no backpressure.
- FILL, receive: on each mem_rvalid, write mem_rdata to data[index][resp_cnt] and increment resp_cnt. Issue and receive proceed concurrently.
- FILL, completion: the response with resp_cnt == WPL-1 also sets valid[index]=1 and tag_arr[index]=tag, then the FSM returns to IDLE. On the next cycle the held request hits.
- valid[index] is cleared on entry to FILL, so a partially filled line is never reported as a hit.
- Stores (IDLE only) are write-through with no write-allocate:
  - mem_we, mem_waddr and mem_wdata are registered and pulse on the cycle after the store.
  - On a hit, the cached word is also updated at the same edge. On a miss, the cache is unchanged.
  - stall=0 for all stores.
- Requests presented during FILL are not accepted (stall=1).
- mem_rvalid in IDLE, or beyond WPL responses, is ignored.
- Reset: state=IDLE, all valid bits=0, counters=0, miss_count=0, mem_req=0, mem_we=0, mem_waddr=0, mem_wdata=0. rdata is don't-care, driven 0. Reset during FILL aborts the fill, and late responses are then ignored.
- Timing (defaults, memory latency L): miss detected at cycle 0; mem_req high cycles 1..8; last response at cycle 8+L; hit at cycle 9+L. stall is high for cycles 0..8+L.

Decomposition:
- Package cache_pkg: FSM state enum (IDLE, FILL), derived-width functions (WPL, TAG_W, word-select width) and MISS_CNT_W=16.
- One sub-module, cache_data_array: 2^INDEX_W × WPL × WORD_W storage with one write port (line, word, data, we) and one combinational read port. Valid and tag storage stay in the controller.

Test Plan:
1. Reset, then read 0x1234, memory latency 3 returning word k = 0xA000+k → stall high for 12 cycles; mem_req for 0x1230,0x1232,…,0x123E; rdata=0xA002 at cycle 12; miss_count=1.
2. After test 1, read 0x123E → stall=0 and rdata=0xA007 in the same cycle; no mem_req; miss_count unchanged.
3. Store 0x1236←0xBEEF (hit) → mem_we pulse next cycle with addr 0x1236 and data 0xBEEF; a subsequent read of 0x1236 returns 0xBEEF without a miss.
4. Read 0x9230 (same index, different tag) → miss and refill; a following read of 0x1230 misses again; miss_count=3.
5. Store to an uncached 0x4000 → mem_we pulse; a following read of 0x4000 misses (no allocate).
6. Assert rst during FILL after 3 responses → next cycle state=IDLE and the line is invalid; remaining mem_rvalid is ignored; re-reading the address performs a full fill.
